fp_shifter_sequencer: RTL and testbench

//  Controller that shares the single 24-bit count_shifter between two requesters: exponent

---
 rtl/fp_shift_pkg.sv | 36 +++
 rtl/lzc24.sv | 21 ++
 rtl/fp_shifter_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_fp_shifter_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_shift_pkg.sv
// Shared types and constants for the shifter sequencer.
// Widths match the external 24-bit count_shifter and its 5-bit counter.
// align_shift() computes the clamped right-shift count for alignment.
package fp_shift_pkg;

  localparam int WIDTH     = 24;
  localparam int EXP_W     = 8;
  localparam int CNT_W     = 5;
  localparam int MAX_SHIFT = 25;
  localparam int TIMEOUT   = 32;
  localparam int WD_W      = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic SRC_ALIGN = 1'b0;
  localparam logic SRC_NORM  = 1'b1;

  // Exponent difference clamped to MAX_SHIFT; a reversed pair yields zero.
  function automatic logic [CNT_W-1:0] align_shift(input logic [EXP_W-1:0] eb,
                                                   input logic [EXP_W-1:0] es);
    logic [EXP_W-1:0] diff;
    diff = eb - es;
    if (eb < es)
      return '0;
    else if (diff > EXP_W'(MAX_SHIFT))
      return CNT_W'(MAX_SHIFT);
    else
      return diff[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/lzc24.sv
// Leading-zero counter for a 24-bit mantissa.
// Purely combinational, zero latency.
// All-zero input reports count 0 with the zero flag set.
module lzc24
  import fp_shift_pkg::*;
(
  input  logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  // Scan upward so the highest set bit is the last one to write the count.
  always_comb begin
    count = '0;
    zero  = (data == '0);
    for (int i = 0; i < WIDTH; i++) begin
      if (data[i]) count = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fp_shifter_sequencer.sv
// Arbitrates alignment and normalisation requests onto one count_shifter.
// Grant cycle t: zero-count result at t+1, otherwise at t+N+3.
// Requests stay pending while busy; a watchdog bounds time spent waiting on the shifter.
module fp_shifter_sequencer
  import fp_shift_pkg::*;
(
  input  logic             Clk,
  input  logic             Clear,
  input  logic             align_req,
  input  logic [EXP_W-1:0] align_eb,
  input  logic [EXP_W-1:0] align_es,
  input  logic [WIDTH-1:0] align_mant,
  input  logic             norm_req,
  input  logic [WIDTH-1:0] norm_mant,
  output logic             align_gnt,
  output logic             norm_gnt,
  output logic             busy,
  output logic             res_valid,
  output logic             res_src,
  output logic [WIDTH-1:0] res_mant,
  output logic             res_guard,
  output logic             res_round,
  output logic             res_sticky,
  output logic [CNT_W-1:0] res_shamt,
  output logic             res_zero,
  output logic             err,
  output logic             sh_load,
  output logic [7:0]       sh_count,
  output logic             sh_dir,
  output logic [WIDTH-1:0] sh_data,
  input  logic             sh_done,
  input  logic [WIDTH-1:0] sh_result,
  input  logic             sh_guard,
  input  logic             sh_round,
  input  logic             sh_sticky
);

  state_t           state;
  logic             last_src;
  logic             op_src;
  logic             op_zero;
  logic [WIDTH-1:0] op_mant;
  logic [CNT_W-1:0] op_cnt;
  logic [WD_W-1:0]  wd_cnt;

  logic [CNT_W-1:0] norm_lz;
  logic             norm_allz;
  logic             pick_norm;
  logic             gnt_pending;

  lzc24 u_lzc (
    .data  (norm_mant),
    .count (norm_lz),
    .zero  (norm_allz)
  );

  // On contention serve whichever source did not win last time.
  always_comb begin
    pick_norm = norm_req;
    if (align_req && norm_req) pick_norm = (last_src == SRC_ALIGN);
  end

  assign gnt_pending = align_gnt | norm_gnt;

  // Sequencer FSM; the grant pulse is issued from IDLE and the next edge launches the operation.
  always_ff @(posedge Clk or posedge Clear) begin
    if (Clear) begin
      state      <= S_IDLE;
      last_src   <= SRC_NORM;
      op_src     <= SRC_ALIGN;
      op_zero    <= 1'b0;
      op_mant    <= '0;
      op_cnt     <= '0;
      wd_cnt     <= '0;
      align_gnt  <= 1'b0;
      norm_gnt   <= 1'b0;
      busy       <= 1'b0;
      res_valid  <= 1'b0;
      res_src    <= 1'b0;
      res_mant   <= '0;
      res_guard  <= 1'b0;
      res_round  <= 1'b0;
      res_sticky <= 1'b0;
      res_shamt  <= '0;
      res_zero   <= 1'b0;
      err        <= 1'b0;
      sh_load    <= 1'b0;
      sh_count   <= '0;
      sh_dir     <= 1'b0;
      sh_data    <= '0;
    end else begin
      align_gnt <= 1'b0;
      norm_gnt  <= 1'b0;
      res_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (gnt_pending) begin
            busy <= 1'b1;
            if (op_cnt == '0) begin
              // Nothing to shift: hand the operand straight back.
              state      <= S_DONE;
              res_valid  <= 1'b1;
              res_src    <= op_src;
              res_mant   <= op_mant;
              res_guard  <= 1'b0;
              res_round  <= 1'b0;
              res_sticky <= 1'b0;
              res_shamt  <= '0;
              res_zero   <= op_zero;
            end else begin
              state    <= S_LOAD;
              sh_load  <= 1'b1;
              sh_data  <= op_mant;
              sh_count <= {3'b000, op_cnt};
              sh_dir   <= op_src;
            end
          end else if (align_req || norm_req) begin
            if (pick_norm) begin
              norm_gnt <= 1'b1;
              last_src <= SRC_NORM;
              op_src   <= SRC_NORM;
              op_mant  <= norm_mant;
              op_cnt   <= norm_lz;
              op_zero  <= norm_allz;
            end else begin
              align_gnt <= 1'b1;
              last_src  <= SRC_ALIGN;
              op_src    <= SRC_ALIGN;
              op_mant   <= align_mant;
              op_cnt    <= align_shift(align_eb, align_es);
              op_zero   <= 1'b0;
              if (align_eb < align_es) err <= 1'b1;
            end
          end
        end

        S_LOAD: begin
          sh_load <= 1'b0;
          wd_cnt  <= '0;
          state   <= S_SHIFT;
        end

        S_SHIFT: begin
          // The first SHIFT cycle still sees the counter from before the load.
          if (wd_cnt != '0 && sh_done) begin
            state      <= S_DONE;
            res_valid  <= 1'b1;
            res_src    <= op_src;
            res_mant   <= sh_result;
            res_guard  <= (op_src == SRC_ALIGN) ? sh_guard  : 1'b0;
            res_round  <= (op_src == SRC_ALIGN) ? sh_round  : 1'b0;
            res_sticky <= (op_src == SRC_ALIGN) ? sh_sticky : 1'b0;
            res_shamt  <= op_cnt;
            res_zero   <= 1'b0;
          end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
            // Shifter never reported completion: flag it and return a zero result.
            state      <= S_DONE;
            err        <= 1'b1;
            res_valid  <= 1'b1;
            res_src    <= op_src;
            res_mant   <= '0;
            res_guard  <= 1'b0;
            res_round  <= 1'b0;
            res_sticky <= 1'b0;
            res_shamt  <= op_cnt;
            res_zero   <= 1'b0;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end

        S_DONE: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          sh_data  <= '0;
          sh_count <= '0;
          sh_dir   <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_shifter_sequencer.sv
// Directed bench for fp_shifter_sequencer with a behavioural count_shifter model.
// Checks latency, shifter commands, GRS results, arbitration, Clear and watchdog.
module tb_fp_shifter_sequencer;

  logic        Clk;
  logic        Clear;
  logic        align_req;
  logic [7:0]  align_eb;
  logic [7:0]  align_es;
  logic [23:0] align_mant;
  logic        norm_req;
  logic [23:0] norm_mant;
  logic        align_gnt, norm_gnt, busy, res_valid, res_src;
  logic [23:0] res_mant;
  logic        res_guard, res_round, res_sticky;
  logic [4:0]  res_shamt;
  logic        res_zero, err, sh_load, sh_dir;
  logic [7:0]  sh_count;
  logic [23:0] sh_data;
  logic        sh_done;
  logic [23:0] sh_result;
  logic        sh_guard, sh_round, sh_sticky;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  // Shifter model state
  logic [4:0]  m_cnt;
  logic [23:0] m_res;
  logic        m_g, m_r, m_s;
  logic        stall;

  // Observations of the load cycle
  logic        saw_load;
  logic [7:0]  ld_cnt;
  logic        ld_dir;
  logic [23:0] ld_data;

  int tg, tv;

  fp_shifter_sequencer dut (
    .Clk        (Clk),
    .Clear      (Clear),
    .align_req  (align_req),
    .align_eb   (align_eb),
    .align_es   (align_es),
    .align_mant (align_mant),
    .norm_req   (norm_req),
    .norm_mant  (norm_mant),
    .align_gnt  (align_gnt),
    .norm_gnt   (norm_gnt),
    .busy       (busy),
    .res_valid  (res_valid),
    .res_src    (res_src),
    .res_mant   (res_mant),
    .res_guard  (res_guard),
    .res_round  (res_round),
    .res_sticky (res_sticky),
    .res_shamt  (res_shamt),
    .res_zero   (res_zero),
    .err        (err),
    .sh_load    (sh_load),
    .sh_count   (sh_count),
    .sh_dir     (sh_dir),
    .sh_data    (sh_data),
    .sh_done    (sh_done),
    .sh_result  (sh_result),
    .sh_guard   (sh_guard),
    .sh_round   (sh_round),
    .sh_sticky  (sh_sticky)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  // Behavioural count_shifter: one bit per cycle, GRS trail the right shift.
  always @(posedge Clk or posedge Clear) begin
    if (Clear) begin
      m_cnt <= '0; m_res <= '0; m_g <= 1'b0; m_r <= 1'b0; m_s <= 1'b0;
    end else if (sh_load) begin
      m_cnt <= sh_count[4:0]; m_res <= sh_data; m_g <= 1'b0; m_r <= 1'b0; m_s <= 1'b0;
    end else if (m_cnt != '0) begin
      m_cnt <= m_cnt - 1'b1;
      if (sh_dir) begin
        m_res <= m_res << 1;
      end else begin
        m_res <= m_res >> 1;
        m_g   <= m_res[0];
        m_r   <= m_g;
        m_s   <= m_s | m_r;
      end
    end
  end

  assign sh_done   = (m_cnt == '0) && !stall;
  assign sh_result = m_res;
  assign sh_guard  = m_g;
  assign sh_round  = m_r;
  assign sh_sticky = m_s;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_gnt(input string tag, input logic want_norm, output int t);
    logic got;
    got = 1'b0;
    t = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if (align_gnt || norm_gnt) begin
        got = 1'b1;
        t = cyc;
        check({tag, "_gnt_norm"}, {31'b0, norm_gnt}, {31'b0, want_norm});
        check({tag, "_gnt_align"}, {31'b0, align_gnt}, {31'b0, ~want_norm});
      end
    end
    check({tag, "_gnt_seen"}, {31'b0, got}, 32'd1);
  endtask

  task automatic wait_res(input string tag, output int t);
    logic got;
    got = 1'b0;
    saw_load = 1'b0;
    t = -1;
    for (int i = 0; i < 60 && !got; i++) begin
      tick();
      if (sh_load) begin
        saw_load = 1'b1; ld_cnt = sh_count; ld_dir = sh_dir; ld_data = sh_data;
      end
      if (res_valid) begin
        got = 1'b1;
        t = cyc;
      end
    end
    check({tag, "_res_seen"}, {31'b0, got}, 32'd1);
  endtask

  task automatic do_align(input string tag, input logic [7:0] eb, input logic [7:0] es,
                          input logic [23:0] m);
    align_eb = eb; align_es = es; align_mant = m; align_req = 1'b1;
    wait_gnt(tag, 1'b0, tg);
    align_req = 1'b0;
    wait_res(tag, tv);
  endtask

  task automatic do_norm(input string tag, input logic [23:0] m);
    norm_mant = m; norm_req = 1'b1;
    wait_gnt(tag, 1'b1, tg);
    norm_req = 1'b0;
    wait_res(tag, tv);
  endtask

  initial begin
    Clear = 1'b1; stall = 1'b0;
    align_req = 1'b0; align_eb = '0; align_es = '0; align_mant = '0;
    norm_req = 1'b0; norm_mant = '0;
    saw_load = 1'b0; ld_cnt = '0; ld_dir = 1'b0; ld_data = '0;
    tick(); tick();
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_valid", {31'b0, res_valid}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_load", {31'b0, sh_load}, 32'd0);
    check("rst_mant", {8'b0, res_mant}, 32'd0);
    Clear = 1'b0;
    tick();

    // Align by 3: 800001 >> 3 leaves the low bit in sticky.
    do_align("al3", 8'd130, 8'd127, 24'h800001);
    check("al3_lat", tv - tg, 32'd6);
    check("al3_ldcnt", {24'b0, ld_cnt}, 32'd3);
    check("al3_lddir", {31'b0, ld_dir}, 32'd0);
    check("al3_lddata", {8'b0, ld_data}, 32'h800001);
    check("al3_mant", {8'b0, res_mant}, 32'h100000);
    check("al3_grs", {29'b0, res_guard, res_round, res_sticky}, 32'b001);
    check("al3_shamt", {27'b0, res_shamt}, 32'd3);
    check("al3_src", {31'b0, res_src}, 32'd0);

    // Difference 100 clamps to 25; MSB ends in round, low bit in sticky.
    do_align("al25", 8'd200, 8'd100, 24'h800001);
    check("al25_lat", tv - tg, 32'd28);
    check("al25_ldcnt", {24'b0, ld_cnt}, 32'd25);
    check("al25_mant", {8'b0, res_mant}, 32'd0);
    check("al25_grs", {29'b0, res_guard, res_round, res_sticky}, 32'b011);
    check("al25_err", {31'b0, err}, 32'd0);

    // Normalise 001234: 11 leading zeros.
    do_norm("nm11", 24'h001234);
    check("nm11_lat", tv - tg, 32'd14);
    check("nm11_ldcnt", {24'b0, ld_cnt}, 32'd11);
    check("nm11_lddir", {31'b0, ld_dir}, 32'd1);
    check("nm11_mant", {8'b0, res_mant}, 32'h91A000);
    check("nm11_shamt", {27'b0, res_shamt}, 32'd11);
    check("nm11_src", {31'b0, res_src}, 32'd1);
    check("nm11_grs", {29'b0, res_guard, res_round, res_sticky}, 32'b000);

    // Already normalised: zero count, shifter untouched.
    do_norm("nm0", 24'h800000);
    check("nm0_lat", tv - tg, 32'd1);
    check("nm0_load", {31'b0, saw_load}, 32'd0);
    check("nm0_mant", {8'b0, res_mant}, 32'h800000);
    check("nm0_zero", {31'b0, res_zero}, 32'd0);

    // All-zero norm operand.
    do_norm("nmz", 24'h000000);
    check("nmz_lat", tv - tg, 32'd1);
    check("nmz_load", {31'b0, saw_load}, 32'd0);
    check("nmz_zero", {31'b0, res_zero}, 32'd1);
    check("nmz_mant", {8'b0, res_mant}, 32'd0);

    // Reversed exponents: error flag, operand passes through unshifted.
    do_align("alrev", 8'd100, 8'd110, 24'h123456);
    check("alrev_lat", tv - tg, 32'd1);
    check("alrev_err", {31'b0, err}, 32'd1);
    check("alrev_mant", {8'b0, res_mant}, 32'h123456);
    check("alrev_shamt", {27'b0, res_shamt}, 32'd0);
    tick();
    check("alrev_err_sticky", {31'b0, err}, 32'd1);

    Clear = 1'b1; tick(); Clear = 1'b0; tick();
    check("clr_err", {31'b0, err}, 32'd0);

    // Contention: align first after reset, then norm, then align again.
    align_eb = 8'd130; align_es = 8'd127; align_mant = 24'h800001;
    norm_mant = 24'h001234;
    align_req = 1'b1; norm_req = 1'b1;
    wait_gnt("arb1", 1'b0, tg);
    align_req = 1'b0;
    wait_res("arb1", tv);
    check("arb1_src", {31'b0, res_src}, 32'd0);
    align_req = 1'b1;
    wait_gnt("arb2", 1'b1, tg);
    norm_req = 1'b0;
    wait_res("arb2", tv);
    check("arb2_src", {31'b0, res_src}, 32'd1);
    check("arb2_mant", {8'b0, res_mant}, 32'h91A000);
    check("arb2_lat", tv - tg, 32'd14);
    wait_gnt("arb3", 1'b0, tg);
    align_req = 1'b0;
    wait_res("arb3", tv);
    check("arb3_mant", {8'b0, res_mant}, 32'h100000);

    // Clear in the middle of a 20-cycle shift.
    align_eb = 8'd140; align_es = 8'd120; align_mant = 24'hABCDEF; align_req = 1'b1;
    wait_gnt("clr", 1'b0, tg);
    align_req = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("clr_busy_pre", {31'b0, busy}, 32'd1);
    Clear = 1'b1;
    tick();
    check("clr_busy", {31'b0, busy}, 32'd0);
    check("clr_valid", {31'b0, res_valid}, 32'd0);
    check("clr_shcount", {24'b0, sh_count}, 32'd0);
    Clear = 1'b0;
    tick();

    // Shifter never completes: watchdog after 32 SHIFT cycles.
    stall = 1'b1;
    do_align("wd", 8'd130, 8'd127, 24'h800001);
    check("wd_lat", tv - tg, 32'd34);
    check("wd_err", {31'b0, err}, 32'd1);
    check("wd_mant", {8'b0, res_mant}, 32'd0);
    stall = 1'b0;
    tick();
    check("wd_idle", {31'b0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
